// File: rtl/hls_deadlock_detect_unit_v2.sv
// hls_deadlock_detect_unit_v2
// Per-process deadlock detector. It merges incoming dependence vectors and
// confirms a deadlock once this process has seen itself in the merged vector
// for STABLE_CYCLES consecutive cycles. It also forwards a report token
// round-robin over the blocked output channels.
// Optional build macro: HLS_DL_DETECT_STICKY_EN. When it is defined,
// CONFIRMED is left only on token_clear.
module hls_deadlock_detect_unit_v2 #(
    parameter int unsigned PROC_NUM      = 4,
    parameter int unsigned PROC_ID       = 0,
    parameter int unsigned IN_CHAN_NUM   = 2,
    parameter int unsigned OUT_CHAN_NUM  = 3,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_mask,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [1:0]                      dl_state,
    output logic [PROC_NUM-1:0]             dl_snapshot
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned PTR_W = (OUT_CHAN_NUM > 1) ? $clog2(OUT_CHAN_NUM) : 1;
    localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRACK     = 2'd1,
        CONFIRMED = 2'd2,
        REPORTED  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    int unsigned       cnt_inc;
    logic [PROC_NUM-1:0] dep_comb;
    logic [PROC_NUM-1:0] dep;
    logic [PROC_NUM-1:0] dep_reg;
    logic              gate;
    logic              any_blocked;
    logic              cand;
    logic              issue;
    logic [PTR_W-1:0]  last_ptr;
    logic [PTR_W-1:0]  pick_ptr;
    logic [PTR_W-1:0]  scan_ptr;
    logic              found;
    int unsigned       scan_pos;
    logic [OUT_CHAN_NUM-1:0] token_next;

    assign any_blocked = |proc_dep_vld_vec;
    assign gate        = ~dl_detect_in | (|token_in_vec);
    assign dep         = gate ? dep_comb : dep_reg;
    assign cand        = gate & dep[PROC_ID] & any_blocked;
    assign issue       = ((|token_in_vec) & ~token_clear) | origin;
    assign cnt_inc     = 32'(cnt) + 32'd1;

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg | SELF_BIT;
    assign dl_detect_out        = (state == CONFIRMED);
    assign dl_state             = state;

    // Merge the valid, unmasked incoming dependence vectors
    always_comb begin
        dep_comb = '0;
        for (int unsigned i = 0; i < IN_CHAN_NUM; i++) begin
            if (in_chan_dep_vld_vec[i] && !in_chan_mask[i]) begin
                dep_comb = dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
            end
        end
    end

    // Pick the next blocked output channel circularly after last_ptr
    always_comb begin
        pick_ptr   = '0;
        found      = 1'b0;
        scan_pos   = 0;
        scan_ptr   = '0;
        token_next = '0;
        for (int unsigned k = 1; k <= OUT_CHAN_NUM; k++) begin
            scan_pos = (32'(last_ptr) + k) % OUT_CHAN_NUM;
            scan_ptr = PTR_W'(scan_pos);
            if (!found && proc_dep_vld_vec[scan_ptr]) begin
                found    = 1'b1;
                pick_ptr = scan_ptr;
            end
        end
        token_next[pick_ptr] = 1'b1;
    end

    // Next-state and stability counter
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (cand) begin
                    cnt_next   = CNT_W'(1);
                    state_next = (STABLE_CYCLES == 1) ? CONFIRMED : TRACK;
                end
            end
            TRACK: begin
                if (cand) begin
                    cnt_next = CNT_W'(cnt_inc);
                    if (cnt_inc == STABLE_CYCLES) begin
                        state_next = CONFIRMED;
                    end
                end else begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            CONFIRMED: begin
                if (token_clear) begin
                    state_next = REPORTED;
                end
`ifndef HLS_DL_DETECT_STICKY_EN
                else if (!cand) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
`endif
            end
            REPORTED: begin
                if (!cand) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Dependence register, token forwarding and confirmation snapshot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dep_reg       <= '0;
            last_ptr      <= '0;
            token_out_vec <= '0;
            dl_snapshot   <= '0;
        end else begin
            dep_reg <= any_blocked ? dep : '0;
            if (issue) begin
                token_out_vec <= token_next;
                last_ptr      <= pick_ptr;
            end else begin
                token_out_vec <= '0;
            end
            if (state_next == CONFIRMED && state != CONFIRMED) begin
                dl_snapshot <= dep;
            end
        end
    end

endmodule

// File: tb/tb_hls_deadlock_detect_unit_v2.sv
// Bench for hls_deadlock_detect_unit_v2 (PROC_NUM=4, PROC_ID=1, 2 in, 3 out,
// STABLE_CYCLES=3): directed scenarios followed by random stimulus, all
// checked against a streak-counting reference model.
module tb_hls_deadlock_detect_unit_v2;

    localparam int PN = 4;
    localparam int PID = 1;
    localparam int IN = 2;
    localparam int ON = 3;
    localparam int SC = 3;
`ifdef HLS_DL_DETECT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [ON-1:0]  proc_dep_vld_vec = '0;
    logic [IN-1:0]  in_chan_dep_vld_vec = '0;
    logic [IN*PN-1:0] in_chan_dep_data_vec = '0;
    logic [IN-1:0]  in_chan_mask = '0;
    logic [IN-1:0]  token_in_vec = '0;
    logic           dl_detect_in = 1'b0;
    logic           origin = 1'b0;
    logic           token_clear = 1'b0;
    logic [ON-1:0]  out_chan_dep_vld_vec;
    logic [PN-1:0]  out_chan_dep_data;
    logic [ON-1:0]  token_out_vec;
    logic           dl_detect_out;
    logic [1:0]     dl_state;
    logic [PN-1:0]  dl_snapshot;

    int checks = 0;
    int errors = 0;

    // reference model: consecutive cand count plus confirmed/reported flags
    int m_dep_reg = 0;
    int m_streak = 0;
    bit m_conf = 0;
    bit m_rep = 0;
    int m_snap = 0;
    int m_tok = 0;
    int m_last = 0;

    hls_deadlock_detect_unit_v2 #(
        .PROC_NUM(4), .PROC_ID(1), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .STABLE_CYCLES(3)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_dep_vld_vec(proc_dep_vld_vec),
        .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
        .in_chan_dep_data_vec(in_chan_dep_data_vec),
        .in_chan_mask(in_chan_mask),
        .token_in_vec(token_in_vec),
        .dl_detect_in(dl_detect_in),
        .origin(origin),
        .token_clear(token_clear),
        .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
        .out_chan_dep_data(out_chan_dep_data),
        .token_out_vec(token_out_vec),
        .dl_detect_out(dl_detect_out),
        .dl_state(dl_state),
        .dl_snapshot(dl_snapshot)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dep_reg = 0; m_streak = 0; m_conf = 0; m_rep = 0;
        m_snap = 0; m_tok = 0; m_last = 0;
    endtask

    // one rising edge of the reference behaviour, using the current inputs
    task automatic model_edge();
        int comb = 0;
        int d;
        int idx = 0;
        bit g, c, got;
        for (int i = 0; i < IN; i++)
            if (in_chan_dep_vld_vec[i] && !in_chan_mask[i])
                comb |= (int'(in_chan_dep_data_vec) >> (i*PN)) & 'hF;
        g = !dl_detect_in || (token_in_vec != 0);
        d = g ? comb : m_dep_reg;
        c = g && (((d >> PID) & 1) == 1) && (proc_dep_vld_vec != 0);
        if (m_rep) begin
            if (!c) begin m_rep = 0; m_streak = 0; end
        end else if (m_conf) begin
            if (token_clear) begin m_conf = 0; m_rep = 1; end
            else if (!c && !STICKY) begin m_conf = 0; m_streak = 0; end
        end else if (c) begin
            m_streak++;
            if (m_streak >= SC) begin m_conf = 1; m_snap = d; end
        end else begin
            m_streak = 0;
        end
        if ((token_in_vec != 0 && !token_clear) || origin) begin
            got = 0;
            for (int k = 1; k <= ON; k++) begin
                int j = (m_last + k) % ON;
                if (!got && proc_dep_vld_vec[j]) begin got = 1; idx = j; end
            end
            m_tok = 1 << idx;
            m_last = idx;
        end else begin
            m_tok = 0;
        end
        m_dep_reg = (proc_dep_vld_vec != 0) ? d : 0;
    endtask

    task automatic check_all();
        int exp_state;
        exp_state = m_rep ? 3 : (m_conf ? 2 : (m_streak > 0 ? 1 : 0));
        check_eq("vld_pass", 32'(out_chan_dep_vld_vec), 32'(proc_dep_vld_vec));
        check_eq("dep_data", 32'(out_chan_dep_data), 32'(m_dep_reg | (1 << PID)));
        check_eq("token", 32'(token_out_vec), 32'(m_tok));
        check_eq("detect", 32'(dl_detect_out), 32'(m_conf));
        check_eq("state", 32'(dl_state), 32'(exp_state));
        check_eq("snapshot", 32'(dl_snapshot), 32'(m_snap));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    // asynchronous reset asserted away from the clock edge
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("rst_detect", 32'(dl_detect_out), 32'd0);
        check_eq("rst_token", 32'(token_out_vec), 32'd0);
        check_eq("rst_snap", 32'(dl_snapshot), 32'd0);
        check_eq("rst_state", 32'(dl_state), 32'd0);
        check_eq("rst_data", 32'(out_chan_dep_data), 32'h2);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        proc_dep_vld_vec = '0; in_chan_dep_vld_vec = '0; in_chan_dep_data_vec = '0;
        in_chan_mask = '0; token_in_vec = '0; dl_detect_in = 0; origin = 0; token_clear = 0;
    endtask

    task automatic self_cand();
        in_chan_dep_vld_vec = 2'b01;
        in_chan_dep_data_vec = 8'b0000_0010;
        proc_dep_vld_vec = 3'b001;
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        // stable self-dependence confirms on the third edge
        self_cand();
        step(); check_eq("d30_c1", 32'(dl_detect_out), 32'd0);
        step(); check_eq("d30_c2", 32'(dl_detect_out), 32'd0);
        step(); check_eq("d30_c3", 32'(dl_detect_out), 32'd1);
        check_eq("d30_snap", 32'(dl_snapshot), 32'h2);
        check_eq("d30_state", 32'(dl_state), 32'd2);

`ifdef HLS_DL_DETECT_STICKY_EN
        in_chan_dep_vld_vec = 2'b00;
        step(); check_eq("d33_sticky", 32'(dl_state), 32'd2);
        token_clear = 1; step(); token_clear = 0;
        check_eq("d33_rep", 32'(dl_state), 32'd3);
        step(); check_eq("d33_idle", 32'(dl_state), 32'd0);
`else
        token_clear = 1; step(); token_clear = 0;
        check_eq("d33_rep", 32'(dl_state), 32'd3);
        check_eq("d33_det", 32'(dl_detect_out), 32'd0);
        step(); check_eq("d33_hold", 32'(dl_state), 32'd3);
        in_chan_dep_vld_vec = 2'b00;
        step(); check_eq("d33_idle", 32'(dl_state), 32'd0);
`endif

        // a dropped cand restarts the count
        idle_inputs(); do_reset();
        self_cand();
        step(); step();
        in_chan_dep_vld_vec = 2'b00;
        step(); check_eq("d31_drop", 32'(dl_state), 32'd0);
        in_chan_dep_vld_vec = 2'b01;
        step(); check_eq("d31_r1", 32'(dl_detect_out), 32'd0);
        step(); check_eq("d31_r2", 32'(dl_detect_out), 32'd0);
        step(); check_eq("d31_r3", 32'(dl_detect_out), 32'd1);

        // masked channel never produces cand
        idle_inputs(); do_reset();
        self_cand(); in_chan_mask = 2'b01;
        for (int i = 0; i < 4; i++) step();
        check_eq("d32_state", 32'(dl_state), 32'd0);
        check_eq("d32_data", 32'(out_chan_dep_data), 32'h2);

        // round-robin token over channels 0 and 2
        idle_inputs(); do_reset();
        proc_dep_vld_vec = 3'b101;
        origin = 1; step(); origin = 0;
        check_eq("d34_pre", 32'(token_out_vec), 32'h4);
        step();
        origin = 1; step(); origin = 0; check_eq("d34_t1", 32'(token_out_vec), 32'h1);
        step(); check_eq("d34_gap", 32'(token_out_vec), 32'h0);
        origin = 1; step(); origin = 0; check_eq("d34_t2", 32'(token_out_vec), 32'h4);
        step();
        origin = 1; token_clear = 1; step(); origin = 0; token_clear = 0;
        check_eq("d34_t3", 32'(token_out_vec), 32'h1);

        // reset taken while CONFIRMED with a token outstanding
        idle_inputs(); do_reset();
        self_cand();
        step(); step();
        origin = 1; step(); origin = 0;
        check_eq("d35_conf", 32'(dl_state), 32'd2);
        do_reset();

        // randomized traffic
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            proc_dep_vld_vec = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            in_chan_dep_vld_vec = 2'($urandom);
            in_chan_mask = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            in_chan_dep_data_vec = 8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h22 : 8'h00);
            token_in_vec = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
            dl_detect_in = ($urandom_range(0, 3) == 0);
            origin = ($urandom_range(0, 5) == 0);
            token_clear = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
